// File: rtl/regfile_wb_forward.sv
// regfile_wb_forward
//   Write-back controller and operand forwarding for the 64x32 register file.
//   Execute results enter a MEM stage register (valid/ready handshake), retire
//   through a WB stage register, and WB drives the regfile write port. Decode
//   read addresses pass straight through to the regfile; the returned data is
//   replaced by in-flight results where possible, otherwise stall is raised.
//
//   Build option: define REGFILE_WB_FORWARD_EN to enable the bypass network.
//   Without it, operands always come from the regfile and decode stalls until
//   any in-flight writer of a source register has committed.
//
// Ports
//   clk, reset                clock, asynchronous active-low reset
//   ex_valid/ex_ready         execute result handshake into MEM
//   ex_rd/ex_regwrite/
//   ex_is_load/ex_result      execute result fields
//   mem_rvalid/mem_rdata      data-memory load return
//   rd_addr1/rd_addr2         decode source registers
//   rf_raddr1/rf_raddr2       regfile read addresses (pass-through)
//   rf_rdata1/rf_rdata2       regfile read data
//   rf_waddr/rf_wdata/rf_wen  regfile write port (from WB registers)
//   op1/op2                   operands returned to decode
//   stall                     decode must hold
module regfile_wb_forward #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 31
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [ADDR_W-1:0] ex_rd,
  input  logic              ex_regwrite,
  input  logic              ex_is_load,
  input  logic [DATA_W-1:0] ex_result,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [ADDR_W-1:0] rf_raddr1,
  output logic [ADDR_W-1:0] rf_raddr2,
  input  logic [DATA_W-1:0] rf_rdata1,
  input  logic [DATA_W-1:0] rf_rdata2,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              rf_wen,
  output logic [DATA_W-1:0] op1,
  output logic [DATA_W-1:0] op2,
  output logic              stall
);

  localparam logic [ADDR_W-1:0] ZR = ADDR_W'(ZERO_REG);

  // MEM stage
  logic              mem_valid, mem_regwrite, mem_is_load;
  logic [ADDR_W-1:0] mem_rd;
  logic [DATA_W-1:0] mem_result;
  // WB stage
  logic              wb_valid, wb_regwrite;
  logic [ADDR_W-1:0] wb_rd;
  logic [DATA_W-1:0] wb_value;

  logic              mem_done;
  logic [DATA_W-1:0] mem_value;

  // A load finishes only when its data returns; mem_rvalid is meaningless otherwise.
  assign mem_done  = mem_valid & (~mem_is_load | mem_rvalid);
  assign mem_value = mem_is_load ? mem_rdata : mem_result;
  assign ex_ready  = ~mem_valid | mem_done;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_valid    <= 1'b0;
      mem_regwrite <= 1'b0;
      mem_is_load  <= 1'b0;
      mem_rd       <= '0;
      mem_result   <= '0;
    end else if (ex_valid && ex_ready) begin
      mem_valid    <= 1'b1;
      // Writes to the hardwired-zero register are dropped at entry so that
      // neither the write port nor the bypass ever sees them.
      mem_regwrite <= ex_regwrite & (ex_rd != ZR);
      mem_is_load  <= ex_is_load;
      mem_rd       <= ex_rd;
      mem_result   <= ex_result;
    end else if (mem_done) begin
      mem_valid    <= 1'b0;
    end
  end

  // WB never stalls: it takes whatever MEM completes, else goes empty.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_valid    <= 1'b0;
      wb_regwrite <= 1'b0;
      wb_rd       <= '0;
      wb_value    <= '0;
    end else begin
      wb_valid <= mem_done;
      if (mem_done) begin
        wb_regwrite <= mem_regwrite;
        wb_rd       <= mem_rd;
        wb_value    <= mem_value;
      end
    end
  end

  assign rf_wen    = wb_valid & wb_regwrite;
  assign rf_waddr  = wb_rd;
  assign rf_wdata  = wb_value;
  assign rf_raddr1 = rd_addr1;
  assign rf_raddr2 = rd_addr2;

  // Returns {stall, value} for one source operand.
  function automatic logic [DATA_W:0] resolve(input logic [ADDR_W-1:0] a,
                                              input logic [DATA_W-1:0] rfd);
    logic mem_hit, wb_hit;
    logic [DATA_W:0] r;
    mem_hit = mem_valid & mem_regwrite & (mem_rd == a) & (a != ZR);
    wb_hit  = wb_valid  & wb_regwrite  & (wb_rd  == a) & (a != ZR);
    r = {1'b0, rfd};
`ifdef REGFILE_WB_FORWARD_EN
    if (mem_hit) begin
      if (!mem_is_load)    r = {1'b0, mem_result};
      else if (mem_rvalid) r = {1'b0, mem_rdata};
      else                 r = {1'b1, rfd};
    end else if (wb_hit) begin
      r = {1'b0, wb_value};
    end
`else
    // WB-stage hits also stall: the regfile only holds the value after WB retires.
    r = {mem_hit | wb_hit, rfd};
`endif
    return r;
  endfunction

  logic [DATA_W:0] res1, res2;
  always_comb begin
    res1  = resolve(rd_addr1, rf_rdata1);
    res2  = resolve(rd_addr2, rf_rdata2);
    op1   = res1[DATA_W-1:0];
    op2   = res2[DATA_W-1:0];
    stall = res1[DATA_W] | res2[DATA_W];
  end

endmodule

// File: tb/tb_regfile_wb_forward.sv
module tb_regfile_wb_forward;
  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid, ex_ready, ex_regwrite, ex_is_load;
  logic [4:0]  ex_rd;
  logic [63:0] ex_result;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;
  logic [4:0]  rd_addr1, rd_addr2, rf_raddr1, rf_raddr2, rf_waddr;
  logic [63:0] rf_rdata1, rf_rdata2, rf_wdata, op1, op2;
  logic        rf_wen, stall;

  int n_chk = 0;
  int n_pass = 0;

  // Behavioural 32-entry register file, X31 reads as zero.
  logic [63:0] rf_m [32] = '{default: 64'd0};
  always @(posedge clk) if (rf_wen && rf_waddr != 5'd31) rf_m[rf_waddr] <= rf_wdata;
  assign rf_rdata1 = (rf_raddr1 == 5'd31) ? 64'd0 : rf_m[rf_raddr1];
  assign rf_rdata2 = (rf_raddr2 == 5'd31) ? 64'd0 : rf_m[rf_raddr2];

  always #5 clk = ~clk;

  regfile_wb_forward dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_is_load(ex_is_load),
    .ex_result(ex_result), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rf_raddr1(rf_raddr1),
    .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_wen(rf_wen),
    .op1(op1), .op2(op2), .stall(stall)
  );

  task chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task tick; @(posedge clk); #1; endtask
  task smp;  @(negedge clk); endtask

  task idle;
    ex_valid = 0; ex_rd = 0; ex_regwrite = 0; ex_is_load = 0; ex_result = 0;
  endtask

  task ex(input logic [4:0] rd, input logic wr, input logic ld, input logic [63:0] res);
    ex_valid = 1; ex_rd = rd; ex_regwrite = wr; ex_is_load = ld; ex_result = res;
  endtask

  initial begin
    reset = 0; idle; mem_rvalid = 0; mem_rdata = 0; rd_addr1 = 0; rd_addr2 = 0;
    tick; smp;
    chk("rst_wen", rf_wen, 0); chk("rst_waddr", rf_waddr, 0);
    chk("rst_wdata", rf_wdata, 0); chk("rst_ready", ex_ready, 1);
    chk("rst_stall", stall, 0);
    tick; reset = 1;

    // Back-to-back ALU: X1=5, then dependent read of X1
    ex(1, 1, 0, 5); smp; chk("b2b_ready", ex_ready, 1); tick;
`ifdef REGFILE_WB_FORWARD_EN
    ex(2, 1, 0, 6); rd_addr1 = 1; smp;
    chk("b2b_op1_mem", op1, 5); chk("b2b_stall", stall, 0); chk("b2b_ready2", ex_ready, 1); tick;
    idle; rd_addr2 = 2; smp;
    chk("b2b_wen", rf_wen, 1); chk("b2b_waddr", rf_waddr, 1); chk("b2b_wdata", rf_wdata, 5);
    chk("b2b_op1_wb", op1, 5); chk("b2b_op2_mem", op2, 6); chk("b2b_stall2", stall, 0); tick;
    smp; chk("b2b_waddr2", rf_waddr, 2); chk("b2b_op1_rf", op1, 5); chk("b2b_op2_wb", op2, 6); tick;
`else
    idle; rd_addr1 = 1; smp;
    chk("nf_stall_mem", stall, 1); tick;
    smp; chk("nf_wen", rf_wen, 1); chk("nf_waddr", rf_waddr, 1); chk("nf_wdata", rf_wdata, 5);
    chk("nf_stall_wb", stall, 1); tick;
    smp; chk("nf_stall_clr", stall, 0); chk("nf_op1_rf", op1, 5); chk("nf_wen_off", rf_wen, 0); tick;
`endif
    rd_addr1 = 0; rd_addr2 = 0;

    // Load-use: X3 load waits two cycles for data
    ex(3, 1, 1, 64'h1234); smp; tick;
    idle; rd_addr2 = 3; mem_rvalid = 0;
    for (int i = 0; i < 2; i++) begin
      smp; chk("ld_stall", stall, 1); chk("ld_ready", ex_ready, 0); tick;
    end
    mem_rvalid = 1; mem_rdata = 64'hDEAD; smp;
    chk("ld_ready_done", ex_ready, 1);
`ifdef REGFILE_WB_FORWARD_EN
    chk("ld_op2", op2, 64'hDEAD); chk("ld_stall_clr", stall, 0);
`else
    chk("nf_ld_stall", stall, 1);
`endif
    tick;
    mem_rvalid = 0; mem_rdata = 0; smp;
    chk("ld_wen", rf_wen, 1); chk("ld_waddr", rf_waddr, 3); chk("ld_wdata", rf_wdata, 64'hDEAD);
`ifdef REGFILE_WB_FORWARD_EN
    chk("ld_op2_wb", op2, 64'hDEAD); chk("ld_stall_wb", stall, 0);
`else
    chk("nf_ld_stall_wb", stall, 1);
`endif
    tick;
    smp; chk("ld_op2_rf", op2, 64'hDEAD); chk("ld_stall_rf", stall, 0); tick;
    rd_addr2 = 0;

    // mem_rvalid with a non-load in MEM must not replace the ALU value
    ex(5, 1, 0, 9); smp; tick;
    idle; mem_rvalid = 1; mem_rdata = 64'h77; smp; chk("nl_ready", ex_ready, 1); tick;
    mem_rvalid = 0; mem_rdata = 0; smp;
    chk("nl_waddr", rf_waddr, 5); chk("nl_wdata", rf_wdata, 9); tick;

    // Zero register: write to X31 dropped, reads give 0
    ex(31, 1, 0, 7); smp; tick;
    idle; rd_addr1 = 31; smp;
    chk("z_op1", op1, 0); chk("z_stall", stall, 0); chk("z_wen", rf_wen, 0); tick;
    smp; chk("z_wen2", rf_wen, 0); chk("z_op1b", op1, 0); tick;
    rd_addr1 = 0;

    // Priority: X4=1 in WB, X4=2 in MEM
    ex(4, 1, 0, 1); smp; tick;
    ex(4, 1, 0, 2); smp; tick;
    idle; rd_addr1 = 4; smp;
    chk("pr_wdata1", rf_wdata, 1);
`ifdef REGFILE_WB_FORWARD_EN
    chk("pr_op1_mem", op1, 2); chk("pr_stall", stall, 0);
`else
    chk("nf_pr_stall", stall, 1);
`endif
    tick;
    smp; chk("pr_wdata2", rf_wdata, 2);
`ifdef REGFILE_WB_FORWARD_EN
    chk("pr_op1_wb", op1, 2);
`else
    chk("nf_pr_stall2", stall, 1);
`endif
    tick;
    smp; chk("pr_op1_rf", op1, 2); chk("pr_stall_rf", stall, 0); tick;
    rd_addr1 = 0;

    // Reset mid-load: X7 in WB, load X6 pending in MEM
    ex(7, 1, 0, 3); smp; tick;
    ex(6, 1, 1, 0); smp; tick;
    idle; rd_addr1 = 7; rd_addr2 = 6; reset = 0; smp;
    chk("rm_wen", rf_wen, 0); chk("rm_ready", ex_ready, 1); chk("rm_stall", stall, 0); tick;
    reset = 1; smp;
    chk("rm_op1", op1, 0); chk("rm_op2", op2, 0); chk("rm_stall2", stall, 0); chk("rm_wen2", rf_wen, 0); tick;
    smp; chk("rm_op1b", op1, 0); chk("rm_op2b", op2, 0); tick;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
